// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: request/grant/response data bus master with
// byte-lane steering, store-data replication and load alignment/extension.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  M_mem_write,
  input  logic [1:0]            M_result_src,
  input  logic [1:0]            M_type_control,
  input  logic                  M_sign_ext_flag,
  input  logic [ADDR_WIDTH-1:0] M_alu_result,
  input  logic [DATA_WIDTH-1:0] M_write_data,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  lsu_stall,
  output logic [DATA_WIDTH-1:0] M_load_data,
  output logic                  misalign
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   load_data_q, load_data_d;

  logic                    is_store, is_load, access, mis_cond;
  logic [3:0]              lane_be;
  logic [DATA_WIDTH-1:0]   store_data, shifted, load_ext;

  assign is_store = M_mem_write;
  assign is_load  = !M_mem_write && (M_result_src == 2'b01);
  assign access   = is_store || is_load;

  always_comb begin
    mis_cond = 1'b0;
    case (M_type_control)
      2'b00:   mis_cond = 1'b0;
      2'b01:   mis_cond = M_alu_result[0];
      default: mis_cond = (M_alu_result[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    lane_be    = 4'b1111;
    store_data = M_write_data;
    case (M_type_control)
      2'b00: begin
        lane_be    = 4'b0001 << M_alu_result[1:0];
        store_data = {4{M_write_data[7:0]}};
      end
      2'b01: begin
        lane_be    = M_alu_result[1] ? 4'b1100 : 4'b0011;
        store_data = {2{M_write_data[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        store_data = M_write_data;
      end
    endcase
  end

  assign shifted = dmem_rdata >> {M_alu_result[1:0], 3'b000};

  always_comb begin
    load_ext = shifted;
    case (M_type_control)
      2'b00:   load_ext = {{(DATA_WIDTH-8){M_sign_ext_flag & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{(DATA_WIDTH-16){M_sign_ext_flag & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // Bus outputs and stall are decoded from the current state; reset gates them
  // off in the same cycle so an abandoned access never drives the bus.
  always_comb begin
    state_d     = state_q;
    load_data_d = load_data_q;
    dmem_req    = 1'b0;
    lsu_stall   = 1'b0;
    misalign    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (access && mis_cond) begin
            misalign    = 1'b1;
            load_data_d = '0;
          end else if (access) begin
            dmem_req  = 1'b1;
            lsu_stall = 1'b1;
            if (dmem_gnt) state_d = is_store ? S_DONE : S_WAIT;
            else          state_d = S_REQ;
          end
        end
        S_REQ: begin
          dmem_req  = 1'b1;
          lsu_stall = 1'b1;
          if (dmem_gnt) state_d = is_store ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          lsu_stall = 1'b1;
          if (dmem_rvalid) begin
            load_data_d = load_ext;
            state_d     = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign dmem_we     = dmem_req && is_store;
  assign dmem_addr   = dmem_req ? {M_alu_result[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign dmem_be     = dmem_req ? lane_be : 4'b0000;
  assign dmem_wdata  = dmem_we ? store_data : '0;
  assign M_load_data = misalign ? '0 : load_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      load_data_q <= load_data_d;
    end
  end

endmodule
